gem_tx_frame_sched: RTL and testbench

//  Frame-granular round-robin scheduler sharing the GEM external-FIFO TX path between NUM_SRC
//  8-bit AXI-Stream sources. Whole frames are forwarded into the TX frame FIFO that feeds
//  gem_ext_fifo_tx. Frames granted but not yet transmitted are capped at MAX_INFLIGHT, using
//  GEM DMA TX end/status toggles as completion credits.

---
 rtl/gem_ext_fifo_pkg.sv | 16 +
 rtl/gem_rr_arbiter.sv | 40 ++++
 rtl/gem_tx_frame_sched.sv | 186 ++++++++++++++++++
 tb/tb_gem_tx_frame_sched.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gem_ext_fifo_pkg.sv
// Shared definitions for the GEM external-FIFO TX frame scheduler.
//   GEM_DATA_W    byte width of the AXI-Stream data path
//   SRC_IDX_W     width of a source index (covers up to 8 sources)
//   sched_state_t scheduler FSM states
package gem_ext_fifo_pkg;

    localparam int GEM_DATA_W = 8;
    localparam int SRC_IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        PASS  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/gem_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request strictly after
// ptr, wrapping around, so the source at ptr itself is considered last.
//   req      in   NUM_SRC     request vector
//   ptr      in   SRC_IDX_W   last winner (always < NUM_SRC)
//   gnt      out  NUM_SRC     one-hot grant (all zero when no request)
//   gnt_idx  out  SRC_IDX_W   index of the granted request
//   gnt_vld  out  1           some request was granted
module gem_rr_arbiter
    import gem_ext_fifo_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [SRC_IDX_W-1:0] ptr,
    output logic [NUM_SRC-1:0]   gnt,
    output logic [SRC_IDX_W-1:0] gnt_idx,
    output logic                 gnt_vld
);

    always_comb begin
        int cand;
        cand    = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            // ptr < NUM_SRC, so a single wrap subtraction is enough
            cand = int'(ptr) + i;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!gnt_vld && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = SRC_IDX_W'(cand);
                gnt_vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gem_tx_frame_sched.sv
// Frame-granular round-robin scheduler feeding the GEM TX frame FIFO from
// NUM_SRC byte-wide AXI-Stream sources. Whole frames are forwarded; the number
// of frames forwarded but not yet completed by GEM is capped at MAX_INFLIGHT,
// with GEM DMA TX end toggles returning credits.
//   clk, rstn          clock, async active-low reset
//   s_axis_*           per-source stream inputs, tready per source
//   m_axis_*           stream to the TX frame FIFO
//   tx_end_tog         each change = one frame completed by GEM
//   tx_status_tog      each change = gem_status valid
//   gem_status         nonzero = errored frame
//   grant_id           current / last granted source
//   inflight           frames forwarded, not yet completed
//   err_cnt            saturating errored-frame count
//   credit_err         sticky: completion seen with nothing in flight
//
// state | meaning
// IDLE  | waiting for a valid source and a free credit
// GRANT | latch the round-robin winner into grant_id
// PASS  | winner's frame passes through combinationally until tlast
module gem_tx_frame_sched
    import gem_ext_fifo_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [GEM_DATA_W*NUM_SRC-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]              s_axis_tvalid,
    input  logic [NUM_SRC-1:0]              s_axis_tlast,
    input  logic [NUM_SRC-1:0]              s_axis_tuser,
    output logic [NUM_SRC-1:0]              s_axis_tready,
    output logic [GEM_DATA_W-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tuser,
    input  logic                            m_axis_tready,
    input  logic                            tx_end_tog,
    input  logic                            tx_status_tog,
    input  logic [3:0]                      gem_status,
    output logic [SRC_IDX_W-1:0]            grant_id,
    output logic [3:0]                      inflight,
    output logic [CNT_W-1:0]                err_cnt,
    output logic                            credit_err
);

    localparam logic [3:0] MAX_INF = 4'(MAX_INFLIGHT);

    sched_state_t          state, state_nxt;
    logic [SRC_IDX_W-1:0]  rr_ptr;
    logic [NUM_SRC-1:0]    grant_oh;
    logic [NUM_SRC-1:0]    arb_gnt;
    logic [SRC_IDX_W-1:0]  arb_idx;
    logic                  arb_vld;
    logic [GEM_DATA_W-1:0] sel_data;
    logic                  sel_valid, sel_last, sel_user;
    logic                  frame_end;
    logic                  end_tog_q, status_tog_q, tog_armed;
    logic                  end_edge, status_edge;

    gem_rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .req     (s_axis_tvalid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // one-hot mux keyed by the registered grant
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_oh[i]) begin
                sel_data  = sel_data | s_axis_tdata[GEM_DATA_W*i +: GEM_DATA_W];
                sel_valid = sel_valid | s_axis_tvalid[i];
                sel_last  = sel_last | s_axis_tlast[i];
                sel_user  = sel_user | s_axis_tuser[i];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        frame_end     = 1'b0;
        case (state)
            IDLE: begin
                if ((|s_axis_tvalid) && (inflight < MAX_INF)) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // a source that withdrew valid before the grant leaves nothing to pass
                state_nxt = arb_vld ? PASS : IDLE;
            end
            PASS: begin
                m_axis_tdata  = sel_data;
                m_axis_tvalid = sel_valid;
                m_axis_tlast  = sel_last;
                m_axis_tuser  = sel_user;
                for (int i = 0; i < NUM_SRC; i++) begin
                    s_axis_tready[i] = grant_oh[i] & m_axis_tready;
                end
                frame_end = sel_valid & sel_last & m_axis_tready;
                if (frame_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            grant_id <= '0;
            grant_oh <= '0;
            rr_ptr   <= SRC_IDX_W'(NUM_SRC - 1);
        end else begin
            state <= state_nxt;
            if ((state == GRANT) && arb_vld) begin
                grant_id <= arb_idx;
                grant_oh <= arb_gnt;
            end
            if (frame_end) begin
                rr_ptr <= grant_id;
            end
        end
    end

    // toggle detectors stay unarmed for one cycle so a level present at
    // reset release is not mistaken for an edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            end_tog_q    <= 1'b0;
            status_tog_q <= 1'b0;
            tog_armed    <= 1'b0;
        end else begin
            end_tog_q    <= tx_end_tog;
            status_tog_q <= tx_status_tog;
            tog_armed    <= 1'b1;
        end
    end

    assign end_edge    = tog_armed & (tx_end_tog ^ end_tog_q);
    assign status_edge = tog_armed & (tx_status_tog ^ status_tog_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight   <= '0;
            credit_err <= 1'b0;
        end else begin
            if (end_edge && (inflight == 4'd0)) begin
                credit_err <= 1'b1;
            end
            if (frame_end && !end_edge) begin
                if (inflight < MAX_INF) begin
                    inflight <= inflight + 4'd1;
                end
            end else if (end_edge && !frame_end) begin
                if (inflight != 4'd0) begin
                    inflight <= inflight - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (status_edge && (gem_status != 4'd0) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gem_tx_frame_sched.sv
module tb_gem_tx_frame_sched;

    localparam int NS   = 4;
    localparam int MAXI = 4;
    localparam int CW   = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic [8*NS-1:0] s_axis_tdata;
    logic [NS-1:0]   s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
    logic [7:0]      m_axis_tdata;
    logic            m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic            tx_end_tog, tx_status_tog;
    logic [3:0]      gem_status;
    logic [2:0]      grant_id;
    logic [3:0]      inflight;
    logic [CW-1:0]   err_cnt;
    logic            credit_err;

    always #5 clk = ~clk;

    gem_tx_frame_sched #(
        .NUM_SRC      (NS),
        .MAX_INFLIGHT (MAXI),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .tx_end_tog    (tx_end_tog),
        .tx_status_tog (tx_status_tog),
        .gem_status    (gem_status),
        .grant_id      (grant_id),
        .inflight      (inflight),
        .err_cnt       (err_cnt),
        .credit_err    (credit_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        int         src;
        logic [7:0] data;
        logic       last;
        logic       user;
    } exp_t;

    typedef struct {
        logic       st_flip;
        logic [3:0] st;
        logic       end_flip;
        int         exp_err;
        logic       exp_cerr;
        int         exp_inf;
    } stat_vec_t;

    beat_t srcq[NS][$];
    exp_t  expq[$];
    bit    mid[NS];
    int    rr_m;
    int    exp_inf;
    bit    exp_cerr;
    int    frames_out;
    int    rdy_mode;
    int    tog_mode;
    bit    stall_en;
    bit    force_flip;
    bit    flip_pending;
    bit    last_mvalid;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int src, input int len, input int base, input bit rnd);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = rnd ? 8'($urandom) : 8'(base + j);
            b.last = (j == len - 1);
            b.user = rnd ? 1'($urandom) : (b.data[7] ^ b.data[0]);
            srcq[src].push_back(b);
        end
    endtask

    // frame-level round robin over the queued frames: next nonempty source after the last winner
    task automatic build_expected();
        int    pos[NS];
        int    nfr[NS];
        int    total;
        int    s;
        bit    found;
        bit    done;
        beat_t b;
        total = 0;
        for (int i = 0; i < NS; i++) begin
            pos[i] = 0;
            nfr[i] = 0;
            foreach (srcq[i][j]) if (srcq[i][j].last) nfr[i]++;
            total += nfr[i];
        end
        while (total > 0) begin
            found = 0;
            for (int k = 1; k <= NS; k++) begin
                s = (rr_m + k) % NS;
                if (!found && nfr[s] > 0) begin
                    found = 1;
                    done  = 0;
                    while (!done) begin
                        b = srcq[s][pos[s]];
                        expq.push_back('{s, b.data, b.last, b.user});
                        pos[s]++;
                        done = b.last;
                    end
                    nfr[s]--;
                    total--;
                    rr_m = s;
                end
            end
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NS; i++) begin
            if (srcq[i].size() > 0 && (!mid[i] || !stall_en || $urandom_range(0, 3) != 0)) begin
                s_axis_tvalid[i]      = 1'b1;
                s_axis_tdata[8*i +: 8] = srcq[i][0].data;
                s_axis_tlast[i]       = srcq[i][0].last;
                s_axis_tuser[i]       = srcq[i][0].user;
            end else begin
                s_axis_tvalid[i]      = 1'b0;
                s_axis_tdata[8*i +: 8] = 8'h00;
                s_axis_tlast[i]       = 1'b0;
                s_axis_tuser[i]       = 1'b0;
            end
        end
    endtask

    // observe at negedge, update model, apply next inputs just after posedge
    task automatic step();
        logic [NS-1:0] hs;
        bit            end_hs;
        bit            dec;
        exp_t          e;
        beat_t         b;
        @(negedge clk);
        hs          = s_axis_tvalid & s_axis_tready;
        last_mvalid = m_axis_tvalid;
        end_hs      = m_axis_tvalid & m_axis_tready & m_axis_tlast;
        chk("ready_onehot", 32'($countones(s_axis_tready) <= 1), 32'd1);
        if (m_axis_tvalid && expq.size() > 0) begin
            chk("s_ready_demux", 32'(s_axis_tready),
                m_axis_tready ? 32'(1 << expq[0].src) : 32'd0);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (expq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_axis_tdata);
            end else begin
                e = expq.pop_front();
                chk("beat_data", 32'(m_axis_tdata), 32'(e.data));
                chk("beat_last", 32'(m_axis_tlast), 32'(e.last));
                chk("beat_user", 32'(m_axis_tuser), 32'(e.user));
                chk("grant_id", 32'(grant_id), 32'(e.src));
            end
            if (m_axis_tlast) frames_out++;
        end
        dec          = flip_pending;
        flip_pending = 0;
        if (dec && exp_inf == 0) exp_cerr = 1;
        if (end_hs && !dec && exp_inf < MAXI) exp_inf++;
        else if (dec && !end_hs && exp_inf > 0) exp_inf--;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) begin
                b      = srcq[i].pop_front();
                mid[i] = !b.last;
            end
        end
        chk("inflight", 32'(inflight), 32'(exp_inf));
        chk("credit_err", 32'(credit_err), 32'(exp_cerr));
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = 1'($urandom_range(0, 1));
            2: m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'b0;
        endcase
        if (force_flip || (tog_mode == 1 && exp_inf > 0 && $urandom_range(0, 3) == 0)) begin
            tx_end_tog   = ~tx_end_tog;
            flip_pending = 1;
            force_flip   = 0;
        end
        drive_sources();
    endtask

    function automatic bit srcs_busy();
        bit busy;
        busy = 0;
        for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) busy = 1;
        return busy;
    endfunction

    task automatic run_drain(input int budget, input string name);
        int c;
        c = 0;
        while ((expq.size() > 0 || srcs_busy()) && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: %0d beats still expected after %0d cycles", name, expq.size(), budget);
            expq.delete();
            for (int i = 0; i < NS; i++) srcq[i].delete();
        end
    endtask

    task automatic drain_inflight(input int budget);
        int c;
        c        = 0;
        tog_mode = 1;
        while (exp_inf > 0 && c < budget) begin
            step();
            c++;
        end
        chk("drain_inflight", 32'(inflight), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        stat_vec_t sv[12];
        int        nf;

        sv[0]  = '{1'b1, 4'd0,  1'b0, 0, 1'b0, 0};
        sv[1]  = '{1'b1, 4'd4,  1'b0, 1, 1'b0, 0};
        sv[2]  = '{1'b1, 4'd1,  1'b0, 2, 1'b0, 0};
        sv[3]  = '{1'b0, 4'd9,  1'b0, 2, 1'b0, 0};
        sv[4]  = '{1'b1, 4'd15, 1'b0, 3, 1'b0, 0};
        sv[5]  = '{1'b1, 4'd2,  1'b1, 4, 1'b1, 0};
        sv[6]  = '{1'b1, 4'd8,  1'b0, 5, 1'b1, 0};
        sv[7]  = '{1'b1, 4'd3,  1'b0, 6, 1'b1, 0};
        sv[8]  = '{1'b1, 4'd0,  1'b0, 6, 1'b1, 0};
        sv[9]  = '{1'b1, 4'd5,  1'b0, 7, 1'b1, 0};
        sv[10] = '{1'b1, 4'd6,  1'b0, 7, 1'b1, 0};
        sv[11] = '{1'b0, 4'd0,  1'b0, 7, 1'b1, 0};

        rstn          = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        tx_end_tog    = 1'b1;
        tx_status_tog = 1'b1;
        gem_status    = 4'd0;
        rr_m          = NS - 1;
        exp_inf       = 0;
        exp_cerr      = 0;
        frames_out    = 0;
        rdy_mode      = 0;
        tog_mode      = 0;
        stall_en      = 0;
        force_flip    = 0;
        flip_pending  = 0;
        last_mvalid   = 0;
        for (int i = 0; i < NS; i++) mid[i] = 0;

        // reset with toggle inputs held high
        #23;
        chk("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_data", 32'(m_axis_tdata), 32'd0);
        chk("rst_m_last", 32'(m_axis_tlast), 32'd0);
        chk("rst_m_user", 32'(m_axis_tuser), 32'd0);
        chk("rst_s_ready", 32'(s_axis_tready), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_credit_err", 32'(credit_err), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) step();

        // round robin over four 3-byte frames
        tog_mode = 1;
        for (int s = 0; s < NS; s++) push_frame(s, 3, 16 * s + 1, 0);
        build_expected();
        frames_out = 0;
        drive_sources();
        run_drain(200, "rr");
        chk("rr_frames", 32'(frames_out), 32'd4);
        drain_inflight(200);

        // credit cap: six frames, no completions
        tog_mode = 0;
        push_frame(0, 2, 8'h40, 0);
        push_frame(0, 2, 8'h44, 0);
        push_frame(1, 2, 8'h50, 0);
        push_frame(1, 2, 8'h54, 0);
        push_frame(2, 2, 8'h60, 0);
        push_frame(3, 2, 8'h70, 0);
        build_expected();
        frames_out = 0;
        drive_sources();
        repeat (80) step();
        chk("cap_frames", 32'(frames_out), 32'd4);
        chk("cap_inflight", 32'(inflight), 32'(MAXI));
        force_flip = 1;
        repeat (40) step();
        chk("cap_fifth", 32'(frames_out), 32'd5);
        tog_mode = 1;
        run_drain(400, "cap");
        drain_inflight(200);

        // frame end and completion edge in the same cycle at inflight=2
        tog_mode = 0;
        push_frame(1, 2, 8'h80, 0);
        push_frame(1, 2, 8'h84, 0);
        build_expected();
        drive_sources();
        run_drain(100, "sim_pre");
        chk("sim_pre_inflight", 32'(inflight), 32'd2);
        rdy_mode      = 3;
        m_axis_tready = 1'b0;
        push_frame(0, 1, 8'h90, 0);
        build_expected();
        drive_sources();
        last_mvalid = 0;
        for (int c = 0; c < 20 && !last_mvalid; c++) step();
        chk("sim_valid_seen", 32'(last_mvalid), 32'd1);
        rdy_mode   = 0;
        force_flip = 1;
        step();
        step();
        chk("sim_inflight", 32'(inflight), 32'd2);
        drain_inflight(200);

        // backpressure on a 5-byte frame from src2
        rdy_mode = 2;
        push_frame(2, 5, 8'hA1, 0);
        build_expected();
        drive_sources();
        run_drain(100, "bp");
        rdy_mode = 0;
        drain_inflight(200);

        // randomized batches against the frame-level model
        stall_en = 1;
        for (int bt = 0; bt < 8; bt++) begin
            rdy_mode = $urandom_range(0, 2);
            tog_mode = 1;
            for (int s = 0; s < NS; s++) begin
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) push_frame(s, $urandom_range(1, 6), 0, 1);
            end
            build_expected();
            drive_sources();
            run_drain(2000, "rand");
        end
        stall_en = 0;
        rdy_mode = 0;
        drain_inflight(200);

        // status toggles, saturation and credit error from a table
        tog_mode = 0;
        for (int r = 0; r < 12; r++) begin
            if (sv[r].st_flip) tx_status_tog = ~tx_status_tog;
            gem_status = sv[r].st;
            if (sv[r].end_flip) tx_end_tog = ~tx_end_tog;
            @(posedge clk);
            #1;
            chk($sformatf("stat%0d_err_cnt", r), 32'(err_cnt), 32'(sv[r].exp_err));
            chk($sformatf("stat%0d_credit_err", r), 32'(credit_err), 32'(sv[r].exp_cerr));
            chk($sformatf("stat%0d_inflight", r), 32'(inflight), 32'(sv[r].exp_inf));
        end
        exp_cerr = 1;

        // async reset in the middle of a frame
        push_frame(1, 5, 8'hC0, 0);
        build_expected();
        drive_sources();
        repeat (4) step();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_m_valid", 32'(m_axis_tvalid), 32'd0);
        chk("arst_s_ready", 32'(s_axis_tready), 32'd0);
        chk("arst_grant_id", 32'(grant_id), 32'd0);
        chk("arst_inflight", 32'(inflight), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("arst_credit_err", 32'(credit_err), 32'd0);
        expq.delete();
        for (int i = 0; i < NS; i++) begin
            srcq[i].delete();
            mid[i] = 0;
        end
        drive_sources();
        rr_m         = NS - 1;
        exp_inf      = 0;
        exp_cerr     = 0;
        flip_pending = 0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) step();

        // IDLE after reset: first beat two cycles after tvalid, pointer restarted at src0
        push_frame(3, 2, 8'hE0, 0);
        push_frame(0, 2, 8'hD0, 0);
        build_expected();
        drive_sources();
        @(negedge clk);
        chk("lat_cycle0", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        chk("lat_cycle1", 32'(m_axis_tvalid), 32'd0);
        step();
        chk("lat_cycle2", 32'(last_mvalid), 32'd1);
        tog_mode = 1;
        run_drain(100, "post_rst");
        drain_inflight(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
